// File: rtl/gpr_wb_pkg.sv
// Shared constants for the GPR write-back arbiter: width defaults and requester indices.
package gpr_wb_pkg;

    localparam int GPR_DATA_W = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int NUM_REQ    = 2;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for a single write-back requester.
// Writes to register 0 complete the handshake but are dropped.
module wb_hold_buf
    import gpr_wb_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int ADDR_W = GPR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_ready,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_adr,
    output logic [DATA_W-1:0] o_data
);

    logic load;

    // Draining and refilling on the same edge keeps a stream bubble-free.
    assign o_ready = !o_full || i_grant;
    assign load    = i_valid && o_ready && (i_adr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_full <= 1'b0;
            o_adr  <= '0;
            o_data <= '0;
        end else if (load) begin
            o_full <= 1'b1;
            o_adr  <= i_adr;
            o_data <= i_data;
        end else if (i_grant) begin
            o_full <= 1'b0;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates ALU (r0) and MEM (r1) write-backs onto one registered GPR write port.
// Define GPR_WB_ARB_RR_EN for round-robin; default build gives MEM fixed priority.
module gpr_wb_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int ADDR_W = GPR_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_r0_valid,
    input  logic                 i_r1_valid,
    output logic                 o_r0_ready,
    output logic                 o_r1_ready,
    input  logic [ADDR_W-1:0]    i_r0_adr,
    input  logic [ADDR_W-1:0]    i_r1_adr,
    input  logic [DATA_W-1:0]    i_r0_data,
    input  logic [DATA_W-1:0]    i_r1_data,
    output logic                 o_wen,
    output logic [ADDR_W-1:0]    o_wreg,
    output logic [DATA_W-1:0]    o_wdata,
    output logic [2**ADDR_W-1:0] o_pend
);

    logic [NUM_REQ-1:0]             valid, ready, full, grant;
    logic [NUM_REQ-1:0][ADDR_W-1:0] adr_in, adr_buf;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_in, data_buf;

    assign valid   = {i_r1_valid, i_r0_valid};
    assign adr_in  = {i_r1_adr, i_r0_adr};
    assign data_in = {i_r1_data, i_r0_data};

    assign o_r0_ready = ready[REQ_ALU];
    assign o_r1_ready = ready[REQ_MEM];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_buf
            wb_hold_buf #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_buf (
                .clk     (clk),
                .rst     (rst),
                .i_valid (valid[gi]),
                .i_adr   (adr_in[gi]),
                .i_data  (data_in[gi]),
                .i_grant (grant[gi]),
                .o_ready (ready[gi]),
                .o_full  (full[gi]),
                .o_adr   (adr_buf[gi]),
                .o_data  (data_buf[gi])
            );
        end
    endgenerate

`ifdef GPR_WB_ARB_RR_EN
    // ptr names the requester preferred on a tie; it flips to the other side after each grant.
    logic ptr;

    always_comb begin
        grant = '0;
        if (&full) grant[ptr] = 1'b1;
        else       grant = full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        ptr <= 1'b0;
        else if (|full) ptr <= grant[REQ_ALU];
    end
`else
    always_comb begin
        grant = '0;
        if (full[REQ_MEM]) grant[REQ_MEM] = 1'b1;
        else               grant[REQ_ALU] = full[REQ_ALU];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wen   <= 1'b0;
            o_wreg  <= '0;
            o_wdata <= '0;
        end else begin
            o_wen <= |full;
            if (|full) begin
                o_wreg  <= grant[REQ_MEM] ? adr_buf[REQ_MEM]  : adr_buf[REQ_ALU];
                o_wdata <= grant[REQ_MEM] ? data_buf[REQ_MEM] : data_buf[REQ_ALU];
            end
        end
    end

    always_comb begin
        o_pend = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (full[i]) o_pend[adr_buf[i]] = 1'b1;
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_gpr_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2**AW;
`ifdef GPR_WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, rst;
    logic          i_r0_valid, i_r1_valid, o_r0_ready, o_r1_ready;
    logic [AW-1:0] i_r0_adr, i_r1_adr, o_wreg;
    logic [DW-1:0] i_r0_data, i_r1_data, o_wdata;
    logic          o_wen;
    logic [NR-1:0] o_pend;

    gpr_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_r0_valid (i_r0_valid),
        .i_r1_valid (i_r1_valid),
        .o_r0_ready (o_r0_ready),
        .o_r1_ready (o_r1_ready),
        .i_r0_adr   (i_r0_adr),
        .i_r1_adr   (i_r1_adr),
        .i_r0_data  (i_r0_data),
        .i_r1_data  (i_r1_data),
        .o_wen      (o_wen),
        .o_wreg     (o_wreg),
        .o_wdata    (o_wdata),
        .o_pend     (o_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: each requester holds at most one pending write in a queue.
    typedef struct {
        int          adr;
        logic [31:0] data;
    } ent_t;

    ent_t          q0[$];
    ent_t          q1[$];
    int            m_ptr;
    logic          exp_wen;
    logic [AW-1:0] exp_wreg;
    logic [DW-1:0] exp_wdata;

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_ptr     = 0;
        exp_wen   = 1'b0;
        exp_wreg  = '0;
        exp_wdata = '0;
    endtask

    function automatic logic [NR-1:0] exp_pend();
        logic [NR-1:0] p = '0;
        foreach (q0[i]) p[q0[i].adr] = 1'b1;
        foreach (q1[i]) p[q1[i].adr] = 1'b1;
        return p;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, "_wen"},   o_wen,   exp_wen);
        chk({tag, "_wreg"},  o_wreg,  exp_wreg);
        chk({tag, "_wdata"}, o_wdata, exp_wdata);
        chk({tag, "_pend"},  o_pend,  exp_pend());
    endtask

    // Drive one cycle of requests, check readiness, clock it, update model, check outputs.
    task automatic step(input string tag,
                        input logic v0, input int a0, input logic [31:0] d0,
                        input logic v1, input int a1, input logic [31:0] d1);
        int   g;
        logic r0, r1;
        ent_t e;
        i_r0_valid = v0; i_r0_adr = a0[AW-1:0]; i_r0_data = d0;
        i_r1_valid = v1; i_r1_adr = a1[AW-1:0]; i_r1_data = d1;
        g = -1;
        if (q0.size() != 0 && q1.size() != 0) g = RR ? m_ptr : 1;
        else if (q1.size() != 0)              g = 1;
        else if (q0.size() != 0)              g = 0;
        r0 = (q0.size() == 0) || (g == 0);
        r1 = (q1.size() == 0) || (g == 1);
        chk({tag, "_rdy0"}, o_r0_ready, r0);
        chk({tag, "_rdy1"}, o_r1_ready, r1);
        @(posedge clk);
        if (g == 0) e = q0.pop_front();
        if (g == 1) e = q1.pop_front();
        if (g >= 0) begin
            exp_wen   = 1'b1;
            exp_wreg  = e.adr[AW-1:0];
            exp_wdata = e.data;
            m_ptr     = (g == 0) ? 1 : 0;
        end else begin
            exp_wen = 1'b0;
        end
        if (v0 && r0 && a0[AW-1:0] != 0) q0.push_back('{a0 % NR, d0});
        if (v1 && r1 && a1[AW-1:0] != 0) q1.push_back('{a1 % NR, d1});
        #1;
        check_outs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    endtask

    initial begin
        logic [AW-1:0] prev;
        int            run;
        rst = 1'b1;
        i_r0_valid = 1'b0; i_r1_valid = 1'b0;
        i_r0_adr = '0; i_r1_adr = '0; i_r0_data = '0; i_r1_data = '0;
        model_reset();
        #1;
        check_outs("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_rdy0", o_r0_ready, 1);
        chk("rst_rdy1", o_r1_ready, 1);

        // Single ALU write to r3: pend between edges, issue after second edge.
        step("s1a", 1'b1, 3, 32'h0000_00AA, 1'b0, 0, 32'h0);
        chk("s1_pend3", o_pend[3], 1);
        chk("s1_wen0", o_wen, 0);
        idle("s1b");
        chk("s1_wen1", o_wen, 1);
        chk("s1_wreg", o_wreg, 3);
        chk("s1_wdata", o_wdata, 32'hAA);
        chk("s1_pend3_clr", o_pend[3], 0);

        // Write to r0 is accepted and dropped.
        step("s2", 1'b0, 0, 32'h0, 1'b1, 0, 32'hFFFF_FFFF);
        chk("s2_rdy1", o_r1_ready, 1);
        chk("s2_wen", o_wen, 0);
        chk("s2_pend", o_pend, 0);

        // Both requesters valid every cycle.
        prev = '0;
        for (int k = 0; k < 6; k++) begin
            step("s3", 1'b1, 1, 32'h100 + k, 1'b1, 2, 32'h200 + k);
            if (k >= 1) begin
                chk("s3_wen", o_wen, 1);
                if (RR) begin
                    if (k >= 2) chk("s3_alt", (o_wreg != prev), 1);
                end else begin
                    chk("s3_wreg_mem", o_wreg, 2);
                    chk("s3_r0_blocked", o_r0_ready, 0);
                end
                prev = o_wreg;
            end
        end
        for (int k = 0; k < 3; k++) idle("s3d");

        // Same destination from both sides: two writes, pend clears after the second.
        step("s4a", 1'b1, 5, 32'h11, 1'b1, 5, 32'h22);
        chk("s4_pend5_a", o_pend[5], 1);
        idle("s4b");
        chk("s4_wen_1st", o_wen, 1);
        chk("s4_pend5_b", o_pend[5], 1);
        idle("s4c");
        chk("s4_wen_2nd", o_wen, 1);
        chk("s4_pend5_c", o_pend[5], 0);
        idle("s4d");

        // Reset with both buffers full drops both writes.
        step("s5a", 1'b1, 12, 32'hC0C0, 1'b1, 13, 32'hD0D0);
        i_r0_valid = 1'b0; i_r1_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_outs("s5_rst");
        chk("s5_rdy0", o_r0_ready, 1);
        chk("s5_rdy1", o_r1_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle("s5b");
        chk("s5_nowen_b", o_wen, 0);
        idle("s5c");
        chk("s5_nowen_c", o_wen, 0);

        // ALU stream r7..r10 with valid held: back-to-back issues.
        run = 0;
        for (int k = 0; k < 4; k++) begin
            step("s6", 1'b1, 7 + k, 32'h700 + k, 1'b0, 0, 32'h0);
            if (o_wen) run++;
        end
        for (int k = 0; k < 3; k++) begin
            idle("s6d");
            if (o_wen && k == 0) run++;
        end
        chk("s6_run", run, 4);

        // Random traffic with address collisions and r0 writes.
        for (int k = 0; k < 400; k++)
            step("rnd",
                 $urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
